// File: rtl/global_defs.sv
// Shared MPU sizing constants.
// Element width, matrix bounds, register count and clock period.
package global_defs;
  localparam int FPBITS = 31;
  localparam int M_MEM = 3;
  localparam int N_MEM = 3;
  localparam int MBITS = $clog2(M_MEM + 1) - 1;
  localparam int NBITS = $clog2(N_MEM + 1) - 1;
  localparam int NUM_ELEMENTS = M_MEM * N_MEM;
  localparam int MATRIX_REGISTERS = 4;
  localparam int MATRIX_REG_BITS =
    $clog2(MATRIX_REGISTERS) - 1;
  localparam int CLOCK_PERIOD = 10;
endpackage

// File: rtl/mpu_pkg.sv
// MPU types: operation enum, load FSM state, field types
// and the register-file write command bundle.
package mpu_pkg;
  import global_defs::*;

  typedef enum logic [2:0] {
    NOP,
    LOAD,
    STORE,
    MULT,
    ADD
  } mpu_operation_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_ACK
  } load_state_t;

  typedef logic [FPBITS:0] elem_t;
  typedef logic [MBITS:0] m_t;
  typedef logic [NBITS:0] n_t;
  typedef logic [MATRIX_REG_BITS:0] maddr_t;

  typedef struct packed {
    logic en;
    maddr_t addr;
    m_t i;
    n_t j;
    m_t m;
    n_t n;
    elem_t elem;
  } wr_cmd_t;
endpackage

// File: rtl/mpu_register_file.sv
// Matrix register bank: one write port, one registered read port.
// Ports: clk, rst, wr_in (write cmd), rd_* (read request/results).
module mpu_register_file
  import global_defs::*;
  import mpu_pkg::*;
(
  input  logic    clk,
  input  logic    rst,
  input  wr_cmd_t wr_in,
  input  logic    rd_en_in,
  input  maddr_t  rd_addr_in,
  input  m_t      rd_i_in,
  input  n_t      rd_j_in,
  output elem_t   rd_elem_out,
  output m_t      rd_m_out,
  output n_t      rd_n_out
);

  elem_t arr_q [MATRIX_REGISTERS][M_MEM][N_MEM];
  m_t    msz_q [MATRIX_REGISTERS];
  n_t    nsz_q [MATRIX_REGISTERS];

  elem_t rd_elem_q, rd_elem_d;
  m_t    rd_m_q, rd_m_d;
  n_t    rd_n_q, rd_n_d;
  logic  rd_in_range;

  // Read indexing ignores stored sizes; only the array bound matters.
  assign rd_in_range = (int'(rd_i_in) < M_MEM) &&
                       (int'(rd_j_in) < N_MEM);

  always_comb begin
    rd_elem_d = rd_elem_q;
    rd_m_d = rd_m_q;
    rd_n_d = rd_n_q;
    if (rd_en_in) begin
      rd_m_d = msz_q[rd_addr_in];
      rd_n_d = nsz_q[rd_addr_in];
      if (rd_in_range) begin
        rd_elem_d = arr_q[rd_addr_in][rd_i_in][rd_j_in];
      end else begin
        rd_elem_d = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < MATRIX_REGISTERS; r++) begin
        msz_q[r] <= '0;
        nsz_q[r] <= '0;
        for (int a = 0; a < M_MEM; a++) begin
          for (int b = 0; b < N_MEM; b++) begin
            arr_q[r][a][b] <= '0;
          end
        end
      end
      rd_elem_q <= '0;
      rd_m_q <= '0;
      rd_n_q <= '0;
    end else begin
      if (wr_in.en) begin
        arr_q[wr_in.addr][wr_in.i][wr_in.j] <= wr_in.elem;
        msz_q[wr_in.addr] <= wr_in.m;
        nsz_q[wr_in.addr] <= wr_in.n;
      end
      rd_elem_q <= rd_elem_d;
      rd_m_q <= rd_m_d;
      rd_n_q <= rd_n_d;
    end
  end

  assign rd_elem_out = rd_elem_q;
  assign rd_m_out = rd_m_q;
  assign rd_n_out = rd_n_q;

endmodule

// File: rtl/mpu_matrix_load_path.sv
// Load sequencer: streams a row-major matrix into a register file.
// Ports: load request/ack/error, register read port for the store path.
module mpu_matrix_load_path
  import global_defs::*;
  import mpu_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     load_en_in,
  input  logic [FPBITS:0]          mem_load_element_in,
  input  logic [MBITS:0]           mem_m_load_size_in,
  input  logic [NBITS:0]           mem_n_load_size_in,
  input  logic [MATRIX_REG_BITS:0] mem_load_addr_in,
  output logic                     mem_load_ack_out,
  output logic                     mem_load_error_out,
  input  logic                     reg_store_en_in,
  input  logic [MATRIX_REG_BITS:0] reg_store_addr_in,
  input  logic [MBITS:0]           reg_i_store_loc_in,
  input  logic [NBITS:0]           reg_j_store_loc_in,
  output logic [FPBITS:0]          reg_store_element_out,
  output logic [MBITS:0]           reg_m_store_size_out,
  output logic [NBITS:0]           reg_n_store_size_out
);

  localparam m_t M_ONE = m_t'(1);
  localparam n_t N_ONE = n_t'(1);

  load_state_t state_q, state_d;
  m_t      i_q, i_d, m_q, m_d;
  n_t      j_q, j_d, n_q, n_d;
  maddr_t  addr_q, addr_d;
  wr_cmd_t wr_q, wr_d;
  logic    ack_q, ack_d;
  logic    err_q, err_d;

  logic size_bad;
  logic last_i;
  logic last_j;

  assign size_bad =
    (mem_m_load_size_in == '0) ||
    (mem_n_load_size_in == '0) ||
    (int'(mem_m_load_size_in) > M_MEM) ||
    (int'(mem_n_load_size_in) > N_MEM);

  assign last_i = (i_q == m_q - M_ONE);
  assign last_j = (j_q == n_q - N_ONE);

  always_comb begin
    state_d = state_q;
    i_d = i_q;
    j_d = j_q;
    m_d = m_q;
    n_d = n_q;
    addr_d = addr_q;
    ack_d = 1'b0;
    err_d = 1'b0;
    wr_d = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (load_en_in) begin
          if (size_bad) begin
            err_d = 1'b1;
          end else begin
            wr_d.en = 1'b1;
            wr_d.addr = mem_load_addr_in;
            wr_d.m = mem_m_load_size_in;
            wr_d.n = mem_n_load_size_in;
            wr_d.elem = mem_load_element_in;
            m_d = mem_m_load_size_in;
            n_d = mem_n_load_size_in;
            addr_d = mem_load_addr_in;
            // Element (0,0) is taken now; point at the next one.
            if (mem_n_load_size_in == N_ONE) begin
              i_d = M_ONE;
              j_d = '0;
            end else begin
              i_d = '0;
              j_d = N_ONE;
            end
            // A 1x1 matrix is already complete.
            if (mem_m_load_size_in == M_ONE &&
                mem_n_load_size_in == N_ONE) begin
              state_d = ST_ACK;
              ack_d = 1'b1;
            end else begin
              state_d = ST_LOAD;
            end
          end
        end
      end
      ST_LOAD: begin
        wr_d.en = 1'b1;
        wr_d.addr = addr_q;
        wr_d.i = i_q;
        wr_d.j = j_q;
        wr_d.m = m_q;
        wr_d.n = n_q;
        wr_d.elem = mem_load_element_in;
        if (last_i && last_j) begin
          state_d = ST_ACK;
          ack_d = 1'b1;
        end else if (last_j) begin
          j_d = '0;
          i_d = i_q + M_ONE;
        end else begin
          j_d = j_q + N_ONE;
        end
      end
      ST_ACK: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      i_q <= '0;
      j_q <= '0;
      m_q <= '0;
      n_q <= '0;
      addr_q <= '0;
      wr_q <= '0;
      ack_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      i_q <= i_d;
      j_q <= j_d;
      m_q <= m_d;
      n_q <= n_d;
      addr_q <= addr_d;
      wr_q <= wr_d;
      ack_q <= ack_d;
      err_q <= err_d;
    end
  end

  assign mem_load_ack_out = ack_q;
  assign mem_load_error_out = err_q;

  mpu_register_file u_rf (
    .clk         (clk),
    .rst         (rst),
    .wr_in       (wr_q),
    .rd_en_in    (reg_store_en_in),
    .rd_addr_in  (reg_store_addr_in),
    .rd_i_in     (reg_i_store_loc_in),
    .rd_j_in     (reg_j_store_loc_in),
    .rd_elem_out (reg_store_element_out),
    .rd_m_out    (reg_m_store_size_out),
    .rd_n_out    (reg_n_store_size_out)
  );

endmodule

// File: tb/tb_mpu_matrix_load_path.sv
// Directed bench for mpu_matrix_load_path.
// Load sequences with cycle checks plus table-driven read-back.
module tb_mpu_matrix_load_path;

  logic        clk = 1'b0;
  logic        rst;
  logic        load_en;
  logic [31:0] ld_elem;
  logic [1:0]  ld_m, ld_n, ld_addr;
  logic        ack, err;
  logic        rd_en;
  logic [1:0]  rd_addr, rd_i, rd_j;
  logic [31:0] rd_elem;
  logic [1:0]  rd_m, rd_n;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  mpu_matrix_load_path dut (
    .clk                   (clk),
    .rst                   (rst),
    .load_en_in            (load_en),
    .mem_load_element_in   (ld_elem),
    .mem_m_load_size_in    (ld_m),
    .mem_n_load_size_in    (ld_n),
    .mem_load_addr_in      (ld_addr),
    .mem_load_ack_out      (ack),
    .mem_load_error_out    (err),
    .reg_store_en_in       (rd_en),
    .reg_store_addr_in     (rd_addr),
    .reg_i_store_loc_in    (rd_i),
    .reg_j_store_loc_in    (rd_j),
    .reg_store_element_out (rd_elem),
    .reg_m_store_size_out  (rd_m),
    .reg_n_store_size_out  (rd_n)
  );

  typedef struct {
    logic [1:0]  a;
    logic [1:0]  i;
    logic [1:0]  j;
    logic [31:0] e;
    logic [1:0]  m;
    logic [1:0]  n;
  } rv_t;

  rv_t vq[$];

  logic [31:0] mat_a [9];
  logic [31:0] mat_b [9];
  logic [31:0] zero9 [9];

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  task automatic rd(input logic [1:0] a, input logic [1:0] i,
                    input logic [1:0] j);
    rd_en = 1'b1;
    rd_addr = a;
    rd_i = i;
    rd_j = j;
    @(posedge clk);
    #1;
    rd_en = 1'b0;
  endtask

  task automatic push(input logic [1:0] a, input logic [1:0] i,
                      input logic [1:0] j, input logic [31:0] e,
                      input logic [1:0] m, input logic [1:0] n);
    rv_t v;
    v.a = a; v.i = i; v.j = j; v.e = e; v.m = m; v.n = n;
    vq.push_back(v);
  endtask

  task automatic run_vq(input string nm);
    foreach (vq[k]) begin
      rd(vq[k].a, vq[k].i, vq[k].j);
      chk($sformatf("%s elem r%0d(%0d,%0d)", nm, vq[k].a,
                    vq[k].i, vq[k].j), rd_elem, vq[k].e);
      chk($sformatf("%s m r%0d", nm, vq[k].a), 32'(rd_m),
          32'(vq[k].m));
      chk($sformatf("%s n r%0d", nm, vq[k].a), 32'(rd_n),
          32'(vq[k].n));
    end
    vq.delete();
  endtask

  // Runs 16 cycles from the load_en cycle (cycle 0), recording
  // ack/error pulses. exp_ack/exp_err of -1 means none expected.
  task automatic do_load(input string nm, input logic [1:0] a,
                         input logic [1:0] m, input logic [1:0] n,
                         input logic [31:0] e [9],
                         input int exp_ack, input int exp_err,
                         input int extra_en);
    int ack_n, ack_c, err_n, err_c, tot;
    ack_n = 0; ack_c = -1; err_n = 0; err_c = -1;
    tot = int'(m) * int'(n);
    for (int c = 0; c < 16; c++) begin
      load_en = (c == 0) || (c == extra_en);
      ld_addr = a;
      ld_m = m;
      ld_n = n;
      ld_elem = (c < tot && c < 9) ? e[c] : 32'h0;
      @(negedge clk);
      if (ack) begin
        ack_n++;
        if (ack_c < 0) ack_c = c;
      end
      if (err) begin
        err_n++;
        if (err_c < 0) err_c = c;
      end
      @(posedge clk);
      #1;
    end
    load_en = 1'b0;
    ld_elem = '0;
    chk({nm, " ack count"}, ack_n, (exp_ack < 0) ? 0 : 1);
    if (exp_ack >= 0) chk({nm, " ack cycle"}, ack_c, exp_ack);
    chk({nm, " err count"}, err_n, (exp_err < 0) ? 0 : 1);
    if (exp_err >= 0) chk({nm, " err cycle"}, err_c, exp_err);
  endtask

  initial begin
    mat_a = '{32'h3f800000, 32'h424951ec, 32'hc0200000,
              32'h3e000000, 32'h3eaaaa9f, 32'h4e932c06,
              32'h00000000, 32'hb6a7c5ac, 32'hd0132c06};
    for (int k = 0; k < 9; k++) begin
      mat_b[k] = 32'h40000000 + 32'(k * 16 + 7);
      zero9[k] = '0;
    end
    rst = 1'b1;
    load_en = 1'b0;
    ld_elem = '0;
    ld_m = '0;
    ld_n = '0;
    ld_addr = '0;
    rd_en = 1'b0;
    rd_addr = '0;
    rd_i = '0;
    rd_j = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state
    chk("rst ack", 32'(ack), 0);
    chk("rst err", 32'(err), 0);
    chk("rst elem out", rd_elem, 0);
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        push(0, 2'(i), 2'(j), 0, 0, 0);
    run_vq("rst");

    // 3x3 into register 0
    do_load("3x3 r0", 0, 3, 3, mat_a, 9, -1, -1);
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        push(0, 2'(i), 2'(j), mat_a[3 * i + j], 3, 3);
    run_vq("3x3");

    // 2x2 into register 1, register 0 untouched
    do_load("2x2 r1", 1, 2, 2, mat_a, 4, -1, -1);
    push(1, 0, 0, mat_a[0], 2, 2);
    push(1, 0, 1, mat_a[1], 2, 2);
    push(1, 1, 0, mat_a[2], 2, 2);
    push(1, 1, 1, mat_a[3], 2, 2);
    push(1, 2, 2, 0, 2, 2);
    push(0, 1, 1, mat_a[4], 3, 3);
    push(0, 2, 2, mat_a[8], 3, 3);
    run_vq("2x2");

    // Rejected sizes
    do_load("m0 err", 2, 0, 3, mat_b, -1, 1, -1);
    do_load("n0 err", 2, 3, 0, mat_b, -1, 1, -1);
    push(2, 0, 0, 0, 0, 0);
    push(0, 0, 0, mat_a[0], 3, 3);
    run_vq("err");

    // Indices past the array bound read as 0
    push(0, 3, 0, 0, 3, 3);
    push(0, 0, 3, 0, 3, 3);
    run_vq("oob");

    // Outputs hold while the read enable is low
    rd(0, 2, 1);
    rd_addr = 1;
    rd_i = 0;
    rd_j = 0;
    @(posedge clk);
    #1;
    chk("hold elem", rd_elem, mat_a[7]);
    chk("hold m", 32'(rd_m), 3);

    // 1x1 load with a same-cycle read of the target location
    load_en = 1'b1;
    ld_addr = 3;
    ld_m = 1;
    ld_n = 1;
    ld_elem = 32'hcafe0001;
    @(posedge clk);
    #1;
    load_en = 1'b0;
    rd_en = 1'b1;
    rd_addr = 3;
    rd_i = 0;
    rd_j = 0;
    @(negedge clk);
    chk("1x1 ack cyc1", 32'(ack), 1);
    @(posedge clk);
    #1;
    rd_en = 1'b0;
    chk("rw same cycle old", rd_elem, 0);
    chk("1x1 ack gone", 32'(ack), 0);
    push(3, 0, 0, 32'hcafe0001, 1, 1);
    run_vq("1x1");

    // 3x1 column exercises the n=1 wrap
    do_load("3x1 r2", 2, 3, 1, mat_b, 3, -1, -1);
    push(2, 0, 0, mat_b[0], 3, 1);
    push(2, 1, 0, mat_b[1], 3, 1);
    push(2, 2, 0, mat_b[2], 3, 1);
    run_vq("3x1");

    // A second load_en during LOAD is ignored
    do_load("extra en", 1, 3, 3, mat_b, 9, -1, 5);
    push(1, 2, 2, mat_b[8], 3, 3);
    push(1, 1, 0, mat_b[3], 3, 3);
    run_vq("extra");

    // Reset in cycle 4 of a 3x3 load aborts it
    begin
      int ack_n, err_n;
      ack_n = 0;
      err_n = 0;
      for (int c = 0; c < 16; c++) begin
        load_en = (c == 0);
        ld_addr = 2;
        ld_m = 3;
        ld_n = 3;
        ld_elem = (c < 9) ? mat_a[c] : 32'h0;
        rst = (c == 4);
        @(negedge clk);
        if (ack) ack_n++;
        if (err) err_n++;
        @(posedge clk);
        #1;
      end
      rst = 1'b0;
      load_en = 1'b0;
      chk("abort ack count", ack_n, 0);
      chk("abort err count", err_n, 0);
    end
    push(0, 0, 0, 0, 0, 0);
    push(1, 2, 2, 0, 0, 0);
    push(2, 0, 0, 0, 0, 0);
    push(2, 0, 1, 0, 0, 0);
    push(3, 0, 0, 0, 0, 0);
    run_vq("abort");

    do_load("post rst 2x2", 0, 2, 2, mat_b, 4, -1, -1);
    push(0, 0, 0, mat_b[0], 2, 2);
    push(0, 1, 1, mat_b[3], 2, 2);
    push(0, 2, 2, 0, 2, 2);
    run_vq("post");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
